npu_postproc_q8_8: RTL and testbench

- Consumes the 38-bit Q22.16 dot-product sum from the 49-lane MAC + pipelined adder-tree datapath.
- Adds a per-output Q8.8 bias, rounds and saturates the result back to Q8.8, and buffers results in a small FIFO.
- Exposes results over a valid/ready stream to the writeback path.
- Decouples the free-running accumulate datapath from a stallable consumer.

---
 rtl/npu_pkg.sv | 15 +
 rtl/npu_sync_fifo.sv | 57 +++++
 rtl/npu_postproc_q8_8.sv | 139 +++++++++++++
 tb/tb_npu_postproc_q8_8.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared fixed-point constants and types for the NPU post-processing path.
package npu_pkg;

    localparam int unsigned Q_IN_FRAC  = 16;
    localparam int unsigned Q_OUT_FRAC = 8;
    localparam int unsigned IN_W       = 38;
    localparam int unsigned OUT_W      = 16;

    typedef logic signed [OUT_W-1:0] q8_8_t;
    typedef logic signed [IN_W-1:0]  q22_16_t;

    localparam q8_8_t SAT_MAX = 16'sh7FFF;
    localparam q8_8_t SAT_MIN = 16'sh8000;

endpackage

// File: rtl/npu_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra MSB to tell full from empty.
module npu_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_ok;
    logic             w_rd_ok;

    // Status and head-of-queue view; data reads as zero while empty.
    always_comb begin
        empty   = (r_wr_ptr == r_rd_ptr);
        full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        count   = r_wr_ptr - r_rd_ptr;
        w_rd_ok = rd_en && !empty;
        w_wr_ok = wr_en && (!full || w_rd_ok);
        rd_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible between write and read.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/npu_postproc_q8_8.sv
// Bias add, round and saturate Q22.16 sums to Q8.8, buffered behind a credit-controlled FWFT FIFO.
// Define NPU_POSTPROC_RELU_EN to clamp negative results to zero before saturation.
module npu_postproc_q8_8 #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IN_W  = 38,
    parameter int unsigned OUT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_sum,
    input  logic [OUT_W-1:0]         bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     sat_flag
);

    import npu_pkg::Q_IN_FRAC;
    import npu_pkg::Q_OUT_FRAC;

    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned SW    = IN_W + 2;
    localparam int unsigned SHIFT = Q_IN_FRAC - Q_OUT_FRAC;
    localparam logic signed [SW-1:0] RND    = SW'(2 ** (SHIFT - 1));
    localparam logic signed [SW-1:0] SAT_HI = SW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SW-1:0] SAT_LO = -SAT_HI - SW'(1);

    logic                  w_accept;
    logic                  w_drop;
    logic [CW:0]           w_credit_used;
    logic signed [SW-1:0]  w_s1_sum;
    logic signed [SW-1:0]  w_rnd;
    logic signed [SW-1:0]  w_shr;
    logic [OUT_W-1:0]      w_s2_data;
    logic                  w_s2_sat;

    logic                  r_s1_valid;
    logic signed [SW-1:0]  r_s1_sum;
    logic                  r_s2_valid;
    logic [OUT_W-1:0]      r_s2_data;
    logic                  r_overflow;
    logic                  r_sat;

    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic [CW-1:0]         w_fifo_count;
    logic [OUT_W-1:0]      w_rd_data;

    // Credits cover every sample already committed to a FIFO slot, so a write never meets a full FIFO.
    always_comb begin
        w_credit_used = (CW+1)'(w_fifo_count) + (CW+1)'(r_s1_valid) + (CW+1)'(r_s2_valid);
        in_ready      = (w_credit_used < (CW+1)'(DEPTH));
        w_accept      = in_valid && in_ready;
        w_drop        = in_valid && !in_ready;
    end

    // Stage 1: align Q8.8 bias to Q.16 and add; the extra headroom bits make overflow impossible.
    always_comb begin
        w_s1_sum = SW'($signed(in_sum)) + (SW'($signed(bias)) <<< SHIFT);
    end

    // Stage 2: round half-up, optional ReLU, saturate to the output rails.
    always_comb begin
        w_rnd     = r_s1_sum + RND;
        w_shr     = w_rnd >>> SHIFT;
        w_s2_data = OUT_W'(w_shr);
        w_s2_sat  = 1'b0;
`ifdef NPU_POSTPROC_RELU_EN
        if (w_shr[SW-1]) begin
            w_s2_data = '0;
        end else if (w_shr > SAT_HI) begin
            w_s2_data = SAT_HI[OUT_W-1:0];
            w_s2_sat  = 1'b1;
        end
`else
        if (w_shr > SAT_HI) begin
            w_s2_data = SAT_HI[OUT_W-1:0];
            w_s2_sat  = 1'b1;
        end else if (w_shr < SAT_LO) begin
            w_s2_data = SAT_LO[OUT_W-1:0];
            w_s2_sat  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_overflow <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sum <= w_s1_sum;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_s2_data;
            end
            if (r_s1_valid && w_s2_sat) begin
                r_sat <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    npu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_s2_valid && !w_fifo_full),
        .wr_data (r_s2_data),
        .rd_en   (out_ready),
        .rd_data (w_rd_data),
        .count   (w_fifo_count),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full)
    );

    always_comb begin
        out_valid  = !w_fifo_empty;
        out_data   = w_rd_data;
        fifo_count = w_fifo_count;
        overflow   = r_overflow;
        sat_flag   = r_sat;
    end

endmodule

// File: tb/tb_npu_postproc_q8_8.sv
// Directed self-checking bench for npu_postproc_q8_8 (default DEPTH=8, Q22.16 in, Q8.8 out).
module tb_npu_postproc_q8_8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [37:0] in_sum;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        sat_flag;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    npu_postproc_q8_8 #(
        .DEPTH (8),
        .IN_W  (38),
        .OUT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .bias       (bias),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .sat_flag   (sat_flag)
    );

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sends one sample with out_ready=1, returns its result and edges-to-visible latency.
    task automatic run_one(input logic [37:0] s, input logic [15:0] b,
                           output logic [15:0] d, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_sum   = s;
        bias     = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        d = out_data;
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++;
        if ({out_valid, out_data, fifo_count, overflow, sat_flag, in_ready} !==
            {1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1})
            begin n_err++; $display("FAIL reset_state got v=%b d=%h c=%0d ov=%b sat=%b rdy=%b exp 0/0000/0/0/0/1",
                out_valid, out_data, fifo_count, overflow, sat_flag, in_ready); end
    endtask

    task automatic test_basic;
        logic [15:0] d;
        int lat;
        out_ready = 1'b1;
        run_one(38'(65536), 16'h0000, d, lat);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        n_cmp++; if (d !== 16'h0100) begin n_err++; $display("FAIL basic_one got=%h exp=0100", d); end
        run_one(38'h80, 16'h0000, d, lat);
        n_cmp++; if (d !== 16'h0001) begin n_err++; $display("FAIL basic_half_up got=%h exp=0001", d); end
        run_one(38'(-128), 16'h0000, d, lat);
        n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL basic_neg_half got=%h exp=0000", d); end
        run_one(38'(-129), 16'h0000, d, lat);
`ifdef NPU_POSTPROC_RELU_EN
        n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL basic_neg_lsb got=%h exp=0000", d); end
`else
        n_cmp++; if (d !== 16'hFFFF) begin n_err++; $display("FAIL basic_neg_lsb got=%h exp=FFFF", d); end
`endif
    endtask

    task automatic test_bias;
        logic [15:0] d;
        int lat;
        run_one(38'(163840), 16'hFF00, d, lat);
        n_cmp++; if (d !== 16'h0180) begin n_err++; $display("FAIL bias_neg got=%h exp=0180", d); end
        run_one(38'(0), 16'h0080, d, lat);
        n_cmp++; if (d !== 16'h0080) begin n_err++; $display("FAIL bias_pos got=%h exp=0080", d); end
    endtask

    task automatic test_saturation;
        logic [15:0] d;
        int lat;
        n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat_pre got=%b exp=0", sat_flag); end
        run_one(38'(8388352), 16'h0000, d, lat);
        n_cmp++; if (d !== 16'h7FFF) begin n_err++; $display("FAIL sat_max_exact got=%h exp=7FFF", d); end
        run_one(38'(-8388608), 16'h0000, d, lat);
`ifdef NPU_POSTPROC_RELU_EN
        n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL sat_min_exact got=%h exp=0000", d); end
`else
        n_cmp++; if (d !== 16'h8000) begin n_err++; $display("FAIL sat_min_exact got=%h exp=8000", d); end
`endif
        n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat_rails_noflag got=%b exp=0", sat_flag); end
        run_one(38'(-13107200), 16'h0000, d, lat);
`ifdef NPU_POSTPROC_RELU_EN
        n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL sat_neg got=%h exp=0000", d); end
        n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat_neg_flag got=%b exp=0", sat_flag); end
`else
        n_cmp++; if (d !== 16'h8000) begin n_err++; $display("FAIL sat_neg got=%h exp=8000", d); end
        n_cmp++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_neg_flag got=%b exp=1", sat_flag); end
`endif
        run_one(38'(13107200), 16'h0000, d, lat);
        n_cmp++; if (d !== 16'h7FFF) begin n_err++; $display("FAIL sat_pos got=%h exp=7FFF", d); end
        n_cmp++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_pos_flag got=%b exp=1", sat_flag); end
    endtask

    task automatic test_backpressure;
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sum   = 38'(i * 256);
            bias     = 16'h0000;
            n_cmp++;
            if (in_ready !== (i <= 8))
                begin n_err++; $display("FAIL bp_in_ready[%0d] got=%b exp=%b", i, in_ready, (i <= 8)); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL bp_count got=%0d exp=8", fifo_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow got=%b exp=1", overflow); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        for (int k = 1; k <= 8; k++) begin
            n_cmp++;
            if (!out_valid || out_data !== 16'(k))
                begin n_err++; $display("FAIL bp_drain[%0d] got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, 16'(k)); end
            @(negedge clk);
            n_cmp++;
            if (out_data !== 16'(k))
                begin n_err++; $display("FAIL bp_hold[%0d] got=%h exp=%h", k, out_data, 16'(k)); end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        n_cmp++;
        if (fifo_count !== 4'd0 || out_valid !== 1'b0)
            begin n_err++; $display("FAIL bp_empty got c=%0d v=%b exp 0/0", fifo_count, out_valid); end
    endtask

    task automatic test_reset_midstream;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL rst_ov_sticky got=%b exp=1", overflow); end
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sum   = (i == 1) ? 38'(13107200) : 38'(i * 256);
            bias     = 16'h0000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (fifo_count !== 4'd5) begin n_err++; $display("FAIL rst_pre_count got=%0d exp=5", fifo_count); end
        n_cmp++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL rst_pre_sat got=%b exp=1", sat_flag); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({fifo_count, out_valid, overflow, sat_flag, in_ready, out_data} !==
            {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000})
            begin n_err++; $display("FAIL rst_mid_state got c=%0d v=%b ov=%b sat=%b rdy=%b d=%h exp 0/0/0/0/1/0000",
                fifo_count, out_valid, overflow, sat_flag, in_ready, out_data); end
        @(negedge clk);
        n_cmp++;
        if (fifo_count !== 4'd0 || out_valid !== 1'b0)
            begin n_err++; $display("FAIL rst_inflight_dropped got c=%0d v=%b exp 0/0", fifo_count, out_valid); end
        begin
            logic [15:0] d;
            int lat;
            out_ready = 1'b1;
            run_one(38'(196608), 16'h0010, d, lat);
            n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rst_fresh_latency got=%0d exp=3", lat); end
            n_cmp++; if (d !== 16'h0310) begin n_err++; $display("FAIL rst_fresh_data got=%h exp=0310", d); end
        end
    endtask

    task automatic test_concurrent;
        int nxt_send = 9;
        int nxt_exp  = 1;
        int cyc      = 0;
        int stalls   = 0;
        int max_cnt  = 0;
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sum   = 38'(i * 256);
            bias     = 16'h0000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL cc_fill got=%0d exp=8", fifo_count); end
        out_ready = 1'b1;
        while (nxt_exp <= 40 && cyc < 300) begin
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (out_valid) begin
                n_cmp++;
                if (out_data !== 16'(nxt_exp))
                    begin n_err++; $display("FAIL cc_data[%0d] got=%h exp=%h", nxt_exp, out_data, 16'(nxt_exp)); end
                nxt_exp++;
            end
            if (nxt_send <= 40) begin
                if (in_ready) begin
                    in_valid = 1'b1;
                    in_sum   = 38'(nxt_send * 256);
                    nxt_send++;
                end else begin
                    in_valid = 1'b0;
                    stalls++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++; if (nxt_exp !== 41) begin n_err++; $display("FAIL cc_drained got=%0d exp=41", nxt_exp - 1); end
        n_cmp++; if (stalls !== 1) begin n_err++; $display("FAIL cc_stall_cycles got=%0d exp=1", stalls); end
        n_cmp++; if (max_cnt > 8) begin n_err++; $display("FAIL cc_max_count got=%0d exp<=8", max_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL cc_overflow got=%b exp=0", overflow); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL cc_final_count got=%0d exp=0", fifo_count); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        bias      = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_bias();
        test_saturation();
        test_backpressure();
        test_reset_midstream();
        test_concurrent();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
